// File: rtl/dbfs_power_accumulator.sv
// Windowed mean-square power of signed PCM samples with a valid/ready output.
// Three-stage pipeline (sample, product, product retime) feeding a window accumulator.
module dbfs_power_accumulator #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int WIN_LOG2     = 10,
  parameter int OUT_WIDTH    = 58
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [SAMPLE_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_clip,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int SQ_W  = 2*SAMPLE_WIDTH-1;
  localparam int ACC_W = SQ_W + WIN_LOG2;
  localparam logic [SAMPLE_WIDTH-1:0] FS_NEG = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic [SAMPLE_WIDTH-1:0] FS_POS = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};

  logic [WIN_LOG2-1:0]     cnt_q, cnt_d;
  logic                    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_clip_q, s1_clip_d;
  logic [SAMPLE_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                    s2_valid_q, s2_valid_d, s2_last_q, s2_last_d, s2_clip_q, s2_clip_d;
  logic [SQ_W-1:0]         s2_sq_q, s2_sq_d;
  logic                    s3_valid_q, s3_valid_d, s3_last_q, s3_last_d, s3_clip_q, s3_clip_d;
  logic [SQ_W-1:0]         s3_sq_q, s3_sq_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    sticky_q, sticky_d;
  logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
  logic                    out_clip_q, out_clip_d;
  logic                    out_valid_q, out_valid_d;

  logic                      adv;
  logic                      accept;
  logic [2*SAMPLE_WIDTH-1:0] s1_ext;
  logic [2*SAMPLE_WIDTH-1:0] prod;
  logic                      prod_msb_unused;
  logic [ACC_W-1:0]          acc_sum;

  // Whole datapath stalls only while a result waits for an unready consumer.
  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = reset_n && adv && !clear;
  assign accept   = in_valid && in_ready;

  // Low bits of the product of sign-extended operands are the exact square; MSB is always 0.
  assign s1_ext          = {{SAMPLE_WIDTH{s1_data_q[SAMPLE_WIDTH-1]}}, s1_data_q};
  assign prod            = s1_ext * s1_ext;
  assign prod_msb_unused = prod[2*SAMPLE_WIDTH-1];
  assign acc_sum         = acc_q + ACC_W'(s3_sq_q);

  always_comb begin
    cnt_d       = cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_clip_d   = s1_clip_q;
    s1_data_d   = s1_data_q;
    s2_valid_d  = s2_valid_q;
    s2_last_d   = s2_last_q;
    s2_clip_d   = s2_clip_q;
    s2_sq_d     = s2_sq_q;
    s3_valid_d  = s3_valid_q;
    s3_last_d   = s3_last_q;
    s3_clip_d   = s3_clip_q;
    s3_sq_d     = s3_sq_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_data_d  = out_data_q;
    out_clip_d  = out_clip_q;
    out_valid_d = out_valid_q;

    if (adv && out_valid_q) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      cnt_d      = '0;
      acc_d      = '0;
      sticky_d   = 1'b0;
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      s3_valid_d = 1'b0;
    end else if (adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_data_d = in_data;
        s1_last_d = (cnt_q == '1);
        s1_clip_d = (in_data == FS_NEG) || (in_data == FS_POS);
        cnt_d     = cnt_q + WIN_LOG2'(1);
      end

      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_clip_d  = s1_clip_q;
      s2_sq_d    = prod[SQ_W-1:0];

      s3_valid_d = s2_valid_q;
      s3_last_d  = s2_last_q;
      s3_clip_d  = s2_clip_q;
      s3_sq_d    = s2_sq_q;

      if (s3_valid_q) begin
        if (s3_last_q) begin
          out_data_d  = OUT_WIDTH'(acc_sum >> WIN_LOG2);
          out_clip_d  = sticky_q | s3_clip_q;
          out_valid_d = 1'b1;
          acc_d       = '0;
          sticky_d    = 1'b0;
        end else begin
          acc_d    = acc_sum;
          sticky_d = sticky_q | s3_clip_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_clip_q   <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_clip_q   <= 1'b0;
      s2_sq_q     <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_clip_q   <= 1'b0;
      s3_sq_q     <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_data_q  <= '0;
      out_clip_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_clip_q   <= s1_clip_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_clip_q   <= s2_clip_d;
      s2_sq_q     <= s2_sq_d;
      s3_valid_q  <= s3_valid_d;
      s3_last_q   <= s3_last_d;
      s3_clip_q   <= s3_clip_d;
      s3_sq_q     <= s3_sq_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_data_q  <= out_data_d;
      out_clip_q  <= out_clip_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_clip  = out_clip_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dbfs_power_accumulator.sv
// Bench for dbfs_power_accumulator: window-level reference model plus directed and random tests.
// Instance 0 uses a 1024-sample window, instance 1 a 4-sample window.
module tb_dbfs_power_accumulator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr   [2];
  logic [23:0] din   [2];
  logic        ivld  [2];
  logic        ordy  [2];
  logic        irdy  [2];
  logic [57:0] odata [2];
  logic        oclip [2];
  logic        ov    [2];

  always #5 clk = ~clk;

  dbfs_power_accumulator #(.SAMPLE_WIDTH(24), .WIN_LOG2(10), .OUT_WIDTH(58)) u0 (
    .clk(clk), .reset_n(reset_n), .clear(clr[0]), .in_data(din[0]), .in_valid(ivld[0]),
    .in_ready(irdy[0]), .out_data(odata[0]), .out_clip(oclip[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]));

  dbfs_power_accumulator #(.SAMPLE_WIDTH(24), .WIN_LOG2(2), .OUT_WIDTH(58)) u1 (
    .clk(clk), .reset_n(reset_n), .clear(clr[1]), .in_data(din[1]), .in_valid(ivld[1]),
    .in_ready(irdy[1]), .out_data(odata[1]), .out_clip(oclip[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]));

  int checks = 0;
  int errors = 0;

  // Reference model state: current window, one in-flight result with its age, pending output.
  bit     m_ov    [2];
  longint m_data  [2];
  bit     m_clip  [2];
  bit     f_v     [2];
  int     f_age   [2];
  longint f_data  [2];
  bit     f_clip  [2];
  longint wsum    [2];
  int     wcnt    [2];
  bit     wclip   [2];
  bit     acc_flag[2];
  int     hs_cnt  [2];

  function automatic int wl(int i);
    return (i == 0) ? 10 : 2;
  endfunction

  function automatic bit is_fs(logic [23:0] d);
    return (d == 24'h800000) || (d == 24'h7fffff);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ov[i] = 0; m_data[i] = 0; m_clip[i] = 0; f_v[i] = 0; f_age[i] = 0;
      wsum[i] = 0; wcnt[i] = 0; wclip[i] = 0; acc_flag[i] = 0;
    end
  endtask

  task automatic model_step(int i);
    bit     adv;
    longint s;
    adv = !(m_ov[i] && !ordy[i]);
    acc_flag[i] = 0;
    if (adv && m_ov[i]) m_ov[i] = 0;
    if (clr[i]) begin
      f_v[i] = 0; wsum[i] = 0; wcnt[i] = 0; wclip[i] = 0;
    end else if (adv) begin
      if (f_v[i]) begin
        f_age[i]++;
        if (f_age[i] == 3) begin
          m_ov[i] = 1; m_data[i] = f_data[i]; m_clip[i] = f_clip[i]; f_v[i] = 0;
        end
      end
      if (ivld[i]) begin
        s = $signed(din[i]);
        wsum[i] += s * s;
        wclip[i] |= is_fs(din[i]);
        wcnt[i]++;
        acc_flag[i] = 1;
        if (wcnt[i] == (1 << wl(i))) begin
          f_v[i] = 1; f_age[i] = 0;
          f_data[i] = wsum[i] / longint'(1 << wl(i));
          f_clip[i] = wclip[i];
          wsum[i] = 0; wcnt[i] = 0; wclip[i] = 0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d_in_ready", i), 64'(irdy[i]),
            64'(reset_n && !clr[i] && !(m_ov[i] && !ordy[i])));
        chk($sformatf("u%0d_out_valid", i), 64'(ov[i]), 64'(m_ov[i]));
        if (m_ov[i]) begin
          chk($sformatf("u%0d_out_data", i), 64'(odata[i]), m_data[i]);
          chk($sformatf("u%0d_out_clip", i), 64'(oclip[i]), 64'(m_clip[i]));
        end
        if (!reset_n) begin
          chk($sformatf("u%0d_rst_data", i), 64'(odata[i]), 64'd0);
          chk($sformatf("u%0d_rst_clip", i), 64'(oclip[i]), 64'd0);
        end
        if (reset_n && ov[i] && ordy[i]) begin
          hs_cnt[i]++;
          $display("result u%0d data=%0d clip=%0d", i, odata[i], oclip[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic send(int i, logic [23:0] d);
    int n = 0;
    din[i] = d;
    ivld[i] = 1'b1;
    do begin
      tick();
      n++;
    end while (!acc_flag[i] && n < 2000);
    if (!acc_flag[i]) chk($sformatf("u%0d_send_timeout", i), 64'd0, 64'd1);
    ivld[i] = 1'b0;
  endtask

  task automatic wait_valid(int i, output int n);
    n = 0;
    while (!ov[i] && n < 5000) begin
      tick();
      n++;
    end
    chk($sformatf("u%0d_wait_valid", i), 64'(ov[i]), 64'd1);
  endtask

  task automatic run_check(int i, string name, longint exp_data, bit exp_clip);
    int n;
    wait_valid(i, n);
    chk({name, "_data"}, 64'(odata[i]), exp_data);
    chk({name, "_clip"}, 64'(oclip[i]), 64'(exp_clip));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs0;
    int hs1;
    for (int i = 0; i < 2; i++) begin
      clr[i] = 0; din[i] = '0; ivld[i] = 0; ordy[i] = 1; hs_cnt[i] = 0;
    end
    reset_n = 1'b0;
    idle(3);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_reset_valid", i), 64'(ov[i]), 64'd0);
      chk($sformatf("u%0d_reset_ready", i), 64'(irdy[i]), 64'd0);
      chk($sformatf("u%0d_reset_data", i), 64'(odata[i]), 64'd0);
    end
    reset_n = 1'b1;
    idle(2);

    // Test 1: constant 4096, latency of exactly 3 cycles after the last accept.
    hs0 = hs_cnt[0];
    repeat (1024) send(0, 24'h001000);
    wait_valid(0, n);
    chk("t1_latency", 64'(n), 64'd3);
    chk("t1_data", 64'(odata[0]), 64'd16777216);
    chk("t1_clip", 64'(oclip[0]), 64'd0);
    idle(5);
    chk("t1_count", 64'(hs_cnt[0] - hs0), 64'd1);

    // Test 2: negative full scale, then sticky cleared on the next window.
    repeat (1024) send(0, 24'h800000);
    run_check(0, "t2a", 64'd70368744177664, 1'b1);
    repeat (1024) send(0, 24'd1000);
    run_check(0, "t2b", 64'd1000000, 1'b0);

    // Test 3: alternating signs with random bubbles.
    for (int k = 0; k < 1024; k++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      send(0, (k % 2 == 1) ? -24'sd1000 : 24'sd1000);
    end
    run_check(0, "t3", 64'd1000000, 1'b0);
    idle(5);

    // Test 5: asynchronous reset pulse mid-window.
    repeat (500) send(0, 24'h001000);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(ov[0]), 64'd0);
    chk("t5_rst_ready", 64'(irdy[0]), 64'd0);
    chk("t5_rst_data", 64'(odata[0]), 64'd0);
    #3 reset_n = 1'b1;
    tick();
    hs0 = hs_cnt[0];
    repeat (1024) send(0, 24'd2);
    run_check(0, "t5", 64'd4, 1'b0);
    idle(5);
    chk("t5_count", 64'(hs_cnt[0] - hs0), 64'd1);

    // Test 4: held result under back-pressure, next window not lost.
    hs1 = hs_cnt[1];
    ordy[1] = 1'b0;
    send(1, 24'd1); send(1, 24'd2); send(1, 24'd3); send(1, 24'd4);
    run_check(1, "t4a", 64'd7, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_hold_data", 64'(odata[1]), 64'd7);
      chk("t4_hold_ready", 64'(irdy[1]), 64'd0);
    end
    fork
      begin repeat (4) send(1, 24'd5); end
      begin idle(4); ordy[1] = 1'b1; end
    join
    run_check(1, "t4b", 64'd25, 1'b0);
    idle(5);
    chk("t4_count", 64'(hs_cnt[1] - hs1), 64'd2);

    // Test 6: clear with a partial window in flight.
    hs1 = hs_cnt[1];
    send(1, 24'd100); send(1, 24'd100);
    clr[1] = 1'b1;
    #1;
    chk("t6_clear_ready", 64'(irdy[1]), 64'd0);
    tick();
    clr[1] = 1'b0;
    send(1, 24'd3); send(1, 24'd3); send(1, 24'd3); send(1, 24'd3);
    run_check(1, "t6", 64'd9, 1'b0);
    idle(5);
    chk("t6_count", 64'(hs_cnt[1] - hs1), 64'd1);

    // Random traffic: data, bubbles, back-pressure and occasional clear.
    for (int k = 0; k < 600; k++) begin
      ordy[1] = ($urandom_range(0, 3) != 0);
      ivld[1] = ($urandom_range(0, 3) != 0);
      clr[1]  = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 7))
        0:       din[1] = 24'h800000;
        1:       din[1] = 24'h7fffff;
        default: din[1] = 24'($urandom());
      endcase
      tick();
    end
    ivld[1] = 0; clr[1] = 0; ordy[1] = 1;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
